// File: rtl/rsenc_pkg.sv
// Shared definitions for the RS(255,223) stream encoder: GF(2^8) arithmetic over
// x^8+x^7+x^2+x+1, the generator polynomial coefficients and the FSM state type.
package rsenc_pkg;

  typedef logic [7:0] gf_t;

  localparam gf_t GF_POLY  = 8'h87;
  localparam gf_t ALPHA    = 8'h02;
  localparam int  NPAR_MAX = 32;

  // Low-order coefficients g[0..NPAR_MAX-1]; g[NPAR] is the implicit monic 1.
  typedef gf_t [NPAR_MAX-1:0] coef_vec_t;

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  function automatic gf_t gf_mul(input gf_t a, input gf_t b);
    gf_t p;
    gf_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    end
    return p;
  endfunction

  // g(x) = prod_{i=0..npar-1} (x + alpha^i), built one root at a time.
  function automatic coef_vec_t gen_poly(input int npar);
    gf_t       c [0:NPAR_MAX];
    gf_t       root;
    coef_vec_t res;
    for (int j = 0; j <= NPAR_MAX; j++) c[j] = '0;
    c[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < npar; i++) begin
      for (int j = NPAR_MAX; j > 0; j--) c[j] = c[j-1] ^ gf_mul(c[j], root);
      c[0] = gf_mul(c[0], root);
      root = gf_mul(root, ALPHA);
    end
    for (int j = 0; j < NPAR_MAX; j++) res[j] = c[j];
    return res;
  endfunction

  localparam coef_vec_t G_COEF = gen_poly(NPAR_MAX);

endpackage

// File: rtl/rsenc_gf_cmul.sv
// Multiply a GF(2^8) symbol by a constant; the constant folds the loop into XORs.
module rsenc_gf_cmul
  import rsenc_pkg::*;
#(
  parameter gf_t C = 8'h01
) (
  input  logic [7:0] i_a,
  output logic [7:0] o_p
);

  assign o_p = gf_mul(i_a, C);

endmodule

// File: rtl/rsenc_stream.sv
// Systematic RS encoder: forwards K message symbols on a valid/ready stream and
// appends NPAR parity symbols from an LFSR division by g(x).
module rsenc_stream
  import rsenc_pkg::*;
#(
  parameter int K    = 223,
  parameter int NPAR = 32
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_parity,
  output logic       out_last
);

  localparam coef_vec_t  G      = (NPAR == NPAR_MAX) ? G_COEF : gen_poly(NPAR);
  localparam logic [7:0] K_LAST = 8'(K - 1);
  localparam logic [7:0] P_LAST = 8'(NPAR - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  gf_t        r_lfsr [NPAR];
  gf_t        w_prod [NPAR];
  logic [7:0] r_cnt;
  logic       r_out_valid;
  gf_t        r_out_data;
  logic       r_out_parity;
  logic       r_out_last;

  logic       w_advance;
  logic       w_in_ready;
  logic       w_accept;
  logic       w_cnt_wrap;
  gf_t        w_fb;

  assign w_advance  = ~r_out_valid | out_ready;
  assign w_in_ready = (r_state != PARITY) & w_advance & ~flush;
  assign w_accept   = in_valid & w_in_ready;
  assign w_fb       = in_data ^ r_lfsr[NPAR-1];
  assign w_cnt_wrap = (r_state == PARITY) ? (r_cnt == P_LAST) : (r_cnt == K_LAST);

  for (genvar gi = 0; gi < NPAR; gi++) begin : g_cmul
    rsenc_gf_cmul #(.C(G[gi])) u_cmul (
      .i_a (w_fb),
      .o_p (w_prod[gi])
    );
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DATA: if (w_accept) w_state_nxt = w_cnt_wrap ? PARITY : DATA;
      PARITY:     if (w_advance && w_cnt_wrap) w_state_nxt = IDLE;
      default:    w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the LFSR is a small bank of flops, not a RAM, so it is reset like any register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_parity <= 1'b0;
      r_out_last   <= 1'b0;
      for (int i = 0; i < NPAR; i++) r_lfsr[i] <= '0;
    end else if (flush) begin
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_parity <= 1'b0;
      r_out_last   <= 1'b0;
      for (int i = 0; i < NPAR; i++) r_lfsr[i] <= '0;
    end else if (r_state == PARITY) begin
      // Shifting zeros in drains the remainder and leaves the LFSR clear at the end.
      if (w_advance) begin
        r_out_data   <= r_lfsr[NPAR-1];
        r_out_parity <= 1'b1;
        r_out_valid  <= 1'b1;
        r_out_last   <= w_cnt_wrap;
        r_cnt        <= w_cnt_wrap ? 8'd0 : r_cnt + 8'd1;
        r_lfsr[0]    <= '0;
        for (int i = 1; i < NPAR; i++) r_lfsr[i] <= r_lfsr[i-1];
      end
    end else if (w_accept) begin
      r_out_data   <= in_data;
      r_out_parity <= 1'b0;
      r_out_valid  <= 1'b1;
      r_out_last   <= 1'b0;
      r_cnt        <= w_cnt_wrap ? 8'd0 : r_cnt + 8'd1;
      r_lfsr[0]    <= w_prod[0];
      for (int i = 1; i < NPAR; i++) r_lfsr[i] <= r_lfsr[i-1] ^ w_prod[i];
    end else if (w_advance) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_parity = r_out_parity;
  assign out_last   = r_out_last;

endmodule
